// File: rtl/swap_pkg.sv
// Shared phase encodings and default sizes for the memory-swap controller and its responder.
package swap_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_LOAD  = 2'd1,
    PH_COPY  = 2'd2,
    PH_STORE = 2'd3
  } phase_e;

  // Legal phase successors: idle may stay or start a swap, then strictly load->copy->store->idle.
  function automatic logic legal_step(input phase_e prev, input phase_e cur);
    case (prev)
      PH_IDLE:  return (cur == PH_IDLE) || (cur == PH_LOAD);
      PH_LOAD:  return cur == PH_COPY;
      PH_COPY:  return cur == PH_STORE;
      default:  return cur == PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/swap_proto_checker.sv
// Flags illegal sel sequences or w/sel mismatches; viol is same-cycle, proto_err is sticky until reset.
module swap_proto_checker
  import swap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       w,
  output logic       viol,
  output logic       proto_err
);

  phase_e sel_q;

  always_comb begin
    viol = !legal_step(sel_q, phase_e'(sel)) || (w != (sel != 2'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= PH_IDLE;
      proto_err <= 1'b0;
    end else begin
      sel_q <= phase_e'(sel);
      if (viol) proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/swap_mem_responder.sv
// Register-file responder performing a three-phase A/B swap through a temp word, with idle-time host access.
// Optional protocol checker enabled by defining SWAP_PROTO_CHECK_EN.
module swap_mem_responder
  import swap_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic              w,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done,
  output logic              host_err,
  output logic              proto_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tmp;
  logic [ADDR_W-1:0] a_q, b_q;

  logic              viol_c;
  logic              act_c;
  phase_e            phase_c;
  logic [DATA_W-1:0] rd_a_c, rd_b_c, rd_host_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

`ifdef SWAP_PROTO_CHECK_EN
  swap_proto_checker u_checker (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .w         (w),
    .viol      (viol_c),
    .proto_err (proto_err)
  );
`else
  assign viol_c    = 1'b0;
  assign proto_err = 1'b0;
`endif

  assign busy    = (sel != 2'd0);
  assign phase_c = phase_e'(sel);
  assign act_c   = w && !viol_c;

  // Out-of-range addresses read as zero.
  always_comb begin
    rd_a_c    = in_range(a_q)       ? mem[a_q]       : '0;
    rd_b_c    = in_range(b_q)       ? mem[b_q]       : '0;
    rd_host_c = in_range(host_addr) ? mem[host_addr] : '0;
  end

  // Single write port: host owns it while idle, the swap phases own it otherwise.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    case (phase_c)
      PH_IDLE: begin
        wr_en_c   = host_we;
        wr_addr_c = host_addr;
        wr_data_c = host_wdata;
      end
      PH_COPY: begin
        wr_en_c   = act_c;
        wr_addr_c = a_q;
        wr_data_c = rd_b_c;
      end
      PH_STORE: begin
        wr_en_c   = act_c;
        wr_addr_c = b_q;
        wr_data_c = tmp;
      end
      default: ;
    endcase
    wr_en_c = wr_en_c && in_range(wr_addr_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmp        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      host_rdata <= '0;
      done       <= 1'b0;
      host_err   <= 1'b0;
    end else begin
      host_rdata <= rd_host_c;
      done       <= (phase_c == PH_STORE) && act_c;
      host_err   <= host_we && (phase_c != PH_IDLE);
      if (phase_c == PH_LOAD && act_c) tmp <= rd_a_c;
      // Operands are frozen for the whole swap, so they must be valid in the last idle cycle.
      if (phase_c == PH_IDLE) begin
        a_q <= addr_a;
        b_q <= addr_b;
      end
    end
  end

endmodule

// File: doc/swap_mem_responder.md
# swap_mem_responder

Datapath-side responder for the memory-swap controller. It owns a small register-file memory and performs a three-step swap of two words (A and B) through a temp register. Each step is driven by the controller's `sel`/`w` phase outputs. A host port gives read/write access while idle, and a built-in checker flags illegal phase sequences.

## Interface
Parameters:
- `DATA_W`, default 8: word width.
- `DEPTH`, default 8: number of words.
- `ADDR_W`, default 3: address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  2  controller phase: 0 idle, 1 read-A-to-temp, 2 copy-B-to-A, 3 temp-to-B.
- `w`  in  1  controller write flag; legal only as `w == (sel != 0)`.
- `addr_a`  in  ADDR_W  swap operand A address.
- `addr_b`  in  ADDR_W  swap operand B address.
- `host_we`  in  1  host write strobe.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rdata`  out  DATA_W  registered read of `mem[host_addr]`.
- `busy`  out  1  combinational, `sel != 0`.
- `done`  out  1  one-cycle pulse after a completed phase-3 write.
- `host_err`  out  1  one-cycle pulse when a host write is dropped.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- Operand latch:
  - `a_q`/`b_q` load `addr_a`/`addr_b` every cycle with `sel==0`.
  - They are frozen while `sel != 0`, so the addresses must be valid in the last idle cycle.
- Phase actions at the clock edge, only when `w==1` and no violation is detected this cycle:
  - sel=1: `tmp <= mem[a_q]`. No memory write.
  - sel=2: `mem[a_q] <= mem[b_q]`.
  - sel=3: `mem[b_q] <= tmp`; `done` is set for the next cycle.
- Host writes:
  - Accepted only when `sel==0`.
  - When `sel != 0`, a host write is dropped and `host_err` pulses next cycle.
- Host reads:
  - Always allowed.
  - `host_rdata` returns the memory contents as they were before that edge's write.
- Equal addresses (A==B): the swap is legal and leaves memory unchanged.
- Out-of-range address (≥ DEPTH): writes are ignored and reads return 0.
- Protocol rule:
  - Legal sel transitions: 0→0, 0→1, 1→2, 2→3, 3→0.
  - `w` must equal `(sel != 0)`.
  - The checker compares against the previous sel, registered as `sel_q` (reset 0).
  - On a violation: `proto_err` sets the next cycle and stays set until reset; the violating cycle's memory and temp updates are suppressed.
  - Later phases still execute. The affected swap result is undefined, and software must re-initialise.

## Timing
- Reset values: `host_rdata`=0, `done`=0, `host_err`=0, `proto_err`=0. `tmp`, `a_q`, `b_q`, `sel_q` and every memory word are cleared to 0.
- Swap latency:
  - Phase 1 at edge N, phase 2 at N+1, phase 3 at N+2.
  - `done` is high during cycle N+3.
  - New memory contents are visible on `host_rdata` for reads issued from cycle N+3.
- Host read latency: 1 cycle.
- Reset mid-swap: everything is cleared and no `done` is produced. A partially swapped state cannot survive reset.
- Back-to-back swaps:
  - sel goes 3→0→1, with at least one idle cycle in between.
  - Addresses are re-latched in that idle cycle.
- Simultaneous host write and sel 0→1 transition in the same cycle: the host write is accepted, because sel==0 in that cycle.

## Configuration
- Macro: `SWAP_PROTO_CHECK_EN`.
- Defined:
  - The checker is instantiated.
  - `proto_err` behaves as specified above.
  - Violating cycles are suppressed.
- Undefined:
  - No checker logic is built.
  - `proto_err` is tied to 0.
  - Phase actions depend only on `sel` and `w==1`.

## Structure
- Shared package `swap_pkg`:
  - Phase encodings `PH_IDLE=0`, `PH_LOAD=1`, `PH_COPY=2`, `PH_STORE=3`.
  - Default `DATA_W`/`ADDR_W` constants.
  - The same encodings are used by the controller.
- Sub-module `swap_proto_checker`:
  - Inputs: `clk`, `reset`, `sel`, `w`.
  - Outputs: combinational `viol` and registered sticky `proto_err`.
  - Instantiated only under the macro.

## Test plan
- Host writes mem[2]=0x11 and mem[5]=0x22, with addr_a=2 and addr_b=5. Drive sel 0,1,2,3,0 with matching w. Expect mem[2]=0x22, mem[5]=0x11, and done high exactly in the cycle after sel=3.
- Same sequence with addr_a=addr_b=4 and mem[4]=0x5A. Expect mem[4]=0x5A and one done pulse.
- host_we=1 to address 3 while sel=2. Expect mem[3] unchanged, host_err pulse next cycle, and the swap completing correctly.
- Illegal sequence sel 0→2 with w=1 (macro defined). Expect no memory change that cycle, proto_err=1 from the next cycle and held until reset. Repeat with the macro undefined: expect proto_err stays 0 and the copy executes.
- Assert reset while sel=2. Expect all memory words, `done` and `proto_err` equal to 0 in the cycle after reset, and no done pulse.
- Two swaps separated by one idle cycle, with different addresses latched in the idle cycle. Expect both swaps correct and two done pulses spaced 4 cycles apart.
